// File: rtl/alif_multichan_neuron_system.sv
// rtl/alif_multichan_neuron_system.sv - serial-loaded multichannel ALIF neuron (optional ALIF_REFRACTORY_EN)
module alif_multichan_neuron_system #(
    parameter int NUM_CH         = 4,
    parameter int IN_W           = 3,
    parameter int W_W            = 3,
    parameter int V_W            = 8,
    parameter int REFRACT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   input_enable,
    input  logic [NUM_CH*IN_W-1:0] chan,
    input  logic                   load_mode,
    input  logic                   serial_data,
    output logic                   spike_out,
    output logic [V_W-1:0]         v_mem_out,
    output logic                   params_ready
);
    localparam int FRAME = NUM_CH*W_W + 24;
    localparam int CNT_W = $clog2(FRAME + 2);
    localparam int SW    = V_W + W_W + IN_W + $clog2(NUM_CH) + 1;
    localparam int REF_W = $clog2(REFRACT_CYCLES + 2);
    localparam logic [CNT_W-1:0]     FRAME_CNT = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0]     FRAME_SAT = CNT_W'(FRAME + 1);
    localparam logic signed [SW-1:0] VMAX_S    = SW'(2**V_W - 1);
    localparam logic [V_W:0]         VMAX_U    = (V_W+1)'(2**V_W - 1);
`ifdef ALIF_REFRACTORY_EN
    localparam int REFR_LEN = REFRACT_CYCLES;
`else
    localparam int REFR_LEN = 0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} load_state_t;

    load_state_t      state, state_nxt;
    logic             load_d;
    logic [FRAME-1:0] shift_reg;
    logic [FRAME-1:0] active_params;
    logic [CNT_W-1:0] bit_cnt;

    wire load_rise = load_mode & ~load_d;
    wire load_fall = ~load_mode & load_d;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_rise) state_nxt = SHIFT;
            SHIFT:   if (load_fall) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            load_d        <= 1'b0;
            shift_reg     <= '0;
            active_params <= '0;
            bit_cnt       <= '0;
            params_ready  <= 1'b0;
        end else begin
            state  <= state_nxt;
            load_d <= load_mode;
            if (state == IDLE && load_rise) begin
                bit_cnt      <= '0;
                params_ready <= 1'b0;
            end else if (state == SHIFT && load_mode && enable) begin
                shift_reg <= {shift_reg[FRAME-2:0], serial_data};
                if (bit_cnt != FRAME_SAT)
                    bit_cnt <= bit_cnt + CNT_W'(1);
            end else if (state == COMMIT && bit_cnt == FRAME_CNT) begin
                active_params <= shift_reg;
                params_ready  <= 1'b1;
            end
        end
    end

    wire [7:0] leak_rate     = active_params[23:16];
    wire [7:0] threshold_min = active_params[15:8];
    wire [3:0] leak_cycles   = active_params[7:4];
    wire [3:0] adapt_step    = active_params[3:0];

    logic [V_W-1:0]   v;
    logic [7:0]       adapt;
    logic [3:0]       leak_cnt;
    logic [REF_W-1:0] refr_cnt;

    logic                 active_step, leak, in_refr, spike;
    logic signed [SW-1:0] sum, c_ext, w_ext, vn_raw;
    logic [V_W-1:0]       v_next, thr;
    logic [V_W:0]         thr_sum;
    logic [8:0]           adapt_sum;
    logic [7:0]           adapt_inc;

    always_comb begin
        active_step = enable && params_ready && !load_mode;
        // >= so that a reload with a shorter period cannot leave the counter stranded above it
        leak    = (leak_cnt >= leak_cycles);
        in_refr = (refr_cnt != '0);
        sum     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c_ext = SW'($signed({1'b0, chan[i*IN_W +: IN_W]}));
            w_ext = SW'($signed(active_params[24 + i*W_W +: W_W]));
            sum   = sum + c_ext * w_ext;
        end
        if (!input_enable || in_refr)
            sum = '0;
        vn_raw = SW'($signed({1'b0, v})) + sum
               - (leak ? SW'($signed({1'b0, leak_rate})) : SW'(0));
        if (vn_raw[SW-1])
            v_next = '0;
        else if (vn_raw > VMAX_S)
            v_next = VMAX_U[V_W-1:0];
        else
            v_next = vn_raw[V_W-1:0];
        thr_sum   = (V_W+1)'(threshold_min) + (V_W+1)'(adapt);
        thr       = (thr_sum > VMAX_U) ? VMAX_U[V_W-1:0] : thr_sum[V_W-1:0];
        spike     = (v_next >= thr) && !in_refr;
        adapt_sum = {1'b0, adapt} + {5'b0, adapt_step};
        adapt_inc = adapt_sum[8] ? 8'hFF : adapt_sum[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v         <= '0;
            adapt     <= '0;
            leak_cnt  <= '0;
            refr_cnt  <= '0;
            spike_out <= 1'b0;
        end else begin
            spike_out <= 1'b0;
            if (active_step) begin
                leak_cnt <= leak ? 4'd0 : leak_cnt + 4'd1;
                if (spike) begin
                    v         <= '0;
                    spike_out <= 1'b1;
                    adapt     <= adapt_inc;
                    refr_cnt  <= REF_W'(REFR_LEN);
                end else begin
                    v <= v_next;
                    if (leak && adapt != 8'd0)
                        adapt <= adapt - 8'd1;
                    if (in_refr)
                        refr_cnt <= refr_cnt - REF_W'(1);
                end
            end
        end
    end

    assign v_mem_out = v;
endmodule

// File: tb/tb_alif_multichan_neuron_system.sv
// tb/tb_alif_multichan_neuron_system.sv - directed vector bench for alif_multichan_neuron_system
module tb_alif_multichan_neuron_system;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        input_enable;
    logic [11:0] chan;
    logic        load_mode;
    logic        serial_data;
    logic        spike_out;
    logic [7:0]  v_mem_out;
    logic        params_ready;

    int n_tests = 0;
    int n_fail  = 0;

    alif_multichan_neuron_system dut (
        .clk(clk), .reset(reset), .enable(enable), .input_enable(input_enable),
        .chan(chan), .load_mode(load_mode), .serial_data(serial_data),
        .spike_out(spike_out), .v_mem_out(v_mem_out), .params_ready(params_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ie;
        logic [11:0] ch;
        int          exp_v;
        logic        exp_spk;
    } vec_t;

    vec_t vecs[$];

    localparam int P1_LO = 0,  P1_HI = 6;
    localparam int AD_LO = 7,  AD_HI = 32;
    localparam int FL_LO = 33, FL_HI = 37;

    task automatic add(input logic en, input logic ie, input logic [11:0] ch, input int v, input logic s);
        vec_t t;
        t.en = en; t.ie = ie; t.ch = ch; t.exp_v = v; t.exp_spk = s;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] mk_frame(input logic [2:0] w3, input logic [2:0] w2,
                                             input logic [2:0] w1, input logic [2:0] w0,
                                             input logic [7:0] lr, input logic [7:0] th,
                                             input logic [3:0] lc, input logic [3:0] as);
        return {w3, w2, w1, w0, lr, th, lc, as};
    endfunction

    task automatic do_reset;
        reset = 1'b0; load_mode = 1'b0; serial_data = 1'b0;
        enable = 1'b1; input_enable = 1'b0; chan = '0;
        tick; tick;
        reset = 1'b1;
        tick;
    endtask

    task automatic load_frame(input logic [35:0] f, input int nbits, input int exp_ready);
        logic b;
        load_mode = 1'b1;
        tick;
        for (int i = 0; i < nbits; i++) begin
            if (i < 36) b = f[35 - i];
            else        b = 1'b0;
            serial_data = b;
            tick;
        end
        load_mode = 1'b0; serial_data = 1'b0;
        tick;
        check($sformatf("ready_commit_cycle_%0dbits", nbits), int'(params_ready), 0);
        tick;
        check($sformatf("ready_after_%0dbits", nbits), int'(params_ready), exp_ready);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            enable = vecs[i].en; input_enable = vecs[i].ie; chan = vecs[i].ch;
            tick;
            check($sformatf("vec%0d_v", i), int'(v_mem_out), vecs[i].exp_v);
            check($sformatf("vec%0d_spike", i), int'(spike_out), int'(vecs[i].exp_spk));
        end
        enable = 1'b1; input_enable = 1'b0; chan = '0;
    endtask

    logic [35:0] fa, fb, fc, fd;

    initial begin
        fa = mk_frame(3'd1, 3'd1, 3'd1, 3'd1, 8'd0, 8'd100, 4'd0, 4'd0);
        fb = mk_frame(3'd1, 3'd1, 3'd1, 3'd1, 8'd0, 8'd100, 4'd3, 4'd10);
        fc = mk_frame(3'd0, 3'd0, 3'd3, 3'b100, 8'd0, 8'd200, 4'd0, 4'd0);
        fd = mk_frame(3'd0, 3'd0, 3'd0, 3'd3, 8'd0, 8'd255, 4'd0, 4'd0);

        // integrate and fire, enable hold, input gating
        add(1, 1, 12'hFFF, 28, 0);  add(1, 1, 12'hFFF, 56, 0);
        add(0, 1, 12'hFFF, 56, 0);  add(1, 1, 12'hFFF, 84, 0);
        add(1, 1, 12'hFFF, 0, 1);   add(1, 1, 12'hFFF, 28, 0);
        add(1, 0, 12'hFFF, 28, 0);
        // adaptation with leak every 4th step; step 4 is spike+leak, adapt ends at 29
        for (int r = 0; r < 2; r++) begin
            add(1, 1, 12'hFFF, 28, 0); add(1, 1, 12'hFFF, 56, 0);
            add(1, 1, 12'hFFF, 84, 0); add(1, 1, 12'hFFF, 0, 1);
        end
        add(1, 1, 12'hFFF, 28, 0);  add(1, 1, 12'hFFF, 56, 0);
        add(1, 1, 12'hFFF, 84, 0);  add(1, 1, 12'hFFF, 112, 0);
        add(1, 1, 12'hFFF, 0, 1);
        for (int k = 14; k <= 20; k++) add(1, 0, 12'h000, 0, 0);
        add(1, 1, 12'hFFF, 28, 0);  add(1, 1, 12'hFFF, 56, 0);
        add(1, 1, 12'hFFF, 84, 0);  add(1, 1, 12'hFFF, 112, 0);
        add(1, 1, 12'h037, 125, 0); add(1, 1, 12'h001, 0, 1);
        // inhibition clamps at zero
        add(1, 1, 12'h038, 21, 0);  add(1, 1, 12'h038, 42, 0);
        add(1, 1, 12'h007, 14, 0);  add(1, 1, 12'h007, 0, 0);
        add(1, 1, 12'h007, 0, 0);

        reset = 1'b0; enable = 1'b0; input_enable = 1'b0; chan = '0;
        load_mode = 1'b0; serial_data = 1'b0;
        tick; tick;
        check("reset_spike", int'(spike_out), 0);
        check("reset_v", int'(v_mem_out), 0);
        check("reset_ready", int'(params_ready), 0);
        reset = 1'b1; enable = 1'b1;
        tick;

        load_frame(fa, 36, 1);
        run_vecs(P1_LO, P1_HI);

        do_reset;
        load_frame(fb, 36, 1);
        run_vecs(AD_LO, AD_HI);

        do_reset;
        load_frame(fc, 36, 1);
        run_vecs(FL_LO, FL_HI);

        // saturation: 12 steps of +21 then 273 clamps to 255 and fires
        do_reset;
        load_frame(fd, 36, 1);
        input_enable = 1'b1; chan = 12'h007;
        for (int k = 1; k <= 12; k++) begin
            tick;
            check($sformatf("sat_v_step%0d", k), int'(v_mem_out), 21 * k);
        end

        // bad frames clear ready and freeze the neuron at 252
        load_frame(fd, 35, 0);
        input_enable = 1'b1; chan = 12'h007;
        tick;
        check("bad35_v_frozen", int'(v_mem_out), 252);
        check("bad35_spike", int'(spike_out), 0);
        load_frame(fd, 37, 0);
        input_enable = 1'b1; chan = 12'h007;
        tick;
        check("bad37_v_frozen", int'(v_mem_out), 252);

        load_frame(fd, 36, 1);
        input_enable = 1'b1; chan = 12'h007;
        tick;
        check("sat_spike", int'(spike_out), 1);
        check("sat_v_zero", int'(v_mem_out), 0);
        tick;
        check("sat_after_v", int'(v_mem_out), 21);

        // mid-load asynchronous reset
        input_enable = 1'b0;
        load_mode = 1'b1;
        tick;
        for (int i = 0; i < 10; i++) begin
            serial_data = fa[35 - i];
            tick;
        end
        #2 reset = 1'b0;
        #1;
        check("midload_reset_v", int'(v_mem_out), 0);
        check("midload_reset_ready", int'(params_ready), 0);
        check("midload_reset_spike", int'(spike_out), 0);
        load_mode = 1'b0; serial_data = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        load_frame(fa, 36, 1);
        run_vecs(P1_LO, P1_HI);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alif_multichan_neuron_system.md
# alif_multichan_neuron_system

Parametrised successor of the dual-channel ALIF neuron system. It combines a serial parameter loader with one adaptive leaky integrate-and-fire neuron. The neuron has `NUM_CH` input channels, signed per-channel weights, a spike-driven adaptive threshold and an optional refractory period. It sits between the input encoders and the spike bus, and is configured over the same single-wire serial interface.

## Interface
Parameters:
- `NUM_CH`, 4: number of input channels (2..8).
- `IN_W`, 3: unsigned input precision per channel.
- `W_W`, 3: signed two's-complement weight width.
- `V_W`, 8: membrane/threshold width, 8..12.
- `REFRACT_CYCLES`, 2: refractory length in neuron steps (used only with the macro).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global clock enable; when low, all state holds.
- `input_enable`  in  1  gates channel integration.
- `chan`  in  NUM_CH*IN_W  packed inputs; channel i is at `[i*IN_W +: IN_W]`.
- `load_mode`  in  1  serial load window.
- `serial_data`  in  1  serial parameter bit.
- `spike_out`  out  1  registered one-cycle spike pulse.
- `v_mem_out`  out  V_W  membrane register.
- `params_ready`  out  1  a valid parameter set is active.

## Operation
- **Frame:** `FRAME = NUM_CH*W_W + 24` bits, default 36. Fields from MSB to LSB:
  - `weight[NUM_CH-1]` … `weight[0]`
  - `leak_rate[7:0]`, `threshold_min[7:0]`, `leak_cycles[3:0]`, `adapt_step[3:0]`
- **Loader states:** IDLE, SHIFT, COMMIT.
  - A `load_mode` rising edge enters SHIFT and clears `params_ready` and the bit counter.
  - In SHIFT, each `enable` cycle shifts left, with `serial_data` entering bit 0. The first bit sent ends at the MSB.
  - The bit counter saturates at FRAME+1.
  - A `load_mode` falling edge enters COMMIT for one cycle.
  - If count == FRAME, the shadow register copies to the active params and `params_ready` is set to 1.
  - Otherwise the frame is discarded, the old active params are kept, and `params_ready` stays 0.
  - COMMIT always returns to IDLE.
- **Neuron activity:** the neuron is active only when `enable && params_ready && !load_mode`.
- **Leak counter:** counts active cycles. A leak event fires when the counter reaches `leak_cycles`, then the counter returns to 0. `leak_cycles`=0 means a leak event every active cycle.
- **Step arithmetic:** performed in signed width `V_W+W_W+IN_W+clog2(NUM_CH)+1`.
  - `sum = input_enable ? Σ chan[i]*weight[i] : 0`
  - `v_next = v + sum − (leak ? leak_rate : 0)`, clamped to [0, 2^V_W−1].
- **Threshold:** `thr = min(threshold_min + adapt, 2^V_W−1)`. `adapt` is an 8-bit unsigned register.
- **Spike** (`v_next >= thr`):
  - `v <= 0`
  - `spike_out <= 1` for one cycle
  - `adapt <= min(adapt + adapt_step, 255)`
- **No spike:** `v <= v_next`. On a leak event, `adapt` decrements by 1 if it is nonzero.
- **Spike and leak in the same cycle:** the spike takes precedence for `adapt`; no decrement that cycle.
- **Reset:** the asynchronous reset has priority over everything. A reset in mid-load discards the shift register.

## Timing
- **Reset values:** `spike_out`=0, `v_mem_out`=0, `params_ready`=0; all params, `adapt`, the leak counter and the loader state are 0/IDLE.
- **Spike latency:** `spike_out` is asserted in the cycle after the step whose `v_next` crosses threshold. `v_mem_out` shows 0 in that same cycle.
- **`params_ready` latency:** rises 2 cycles after the `load_mode` falling-edge cycle (edge detect, then COMMIT).
- **During loading:** while `load_mode` is high, the neuron is frozen (`v`, `adapt` and the leak counter hold). `spike_out` is 0.
- **With `enable` low:** nothing changes and `spike_out` is forced to 0.

## Configuration
- `ALIF_REFRACTORY_EN` defined:
  - After a spike, the next `REFRACT_CYCLES` active cycles force `sum`=0 and hold `v` at 0.
  - Leak events and `adapt` decay still run during this window.
  - A down-counter tracks the window; it resets to 0.
- `ALIF_REFRACTORY_EN` undefined: no refractory window; integration resumes in the cycle after a spike.

## Test plan
- **Valid load:** after reset, load a 36-bit frame: weights all +1, `leak_rate`=0, `threshold_min`=100, `leak_cycles`=0, `adapt_step`=0. Expect `params_ready`=1 two cycles after `load_mode` falls.
- **Integrate and fire:** with that load, all channels=7 and `input_enable`=1. Expect `v`=28, 56, 84, then a spike (112>=100): `spike_out` pulses once and `v_mem_out` returns to 0.
- **Adaptation:** with `adapt_step`=10 and the same stimulus, the threshold moves 100→110→120 across successive spikes. With inputs then at 0 and `leak_cycles`=3, `adapt` falls by 1 every 4 cycles.
- **Bad frame:** a 35-bit frame leaves `params_ready`=0 and the old params unchanged. A 37-bit frame behaves the same.
- **Inhibition and floor:** weight[0]=−4, chan[0]=7, other channels 0. `v` clamps at 0 and never wraps. `v`=250 with a large positive sum saturates at 255 when `V_W`=8 and `threshold_min`=255.
- **Refractory and mid-load reset:**
  - With `ALIF_REFRACTORY_EN`, `v` holds 0 for 2 steps after each spike.
  - A reset asserted mid-frame returns all outputs to 0, and the next full frame loads correctly.
